// File: rtl/lsu_l1d_req_queue.sv
// lsu_l1d_req_queue
//   In-order LSU request queue between dispatch and the L1D request ports.
//   Holds up to LSQ_ENTRY_NUM memory uops, issues them in program order
//   (loads on the ld channel, stores/fences on the st channel), tracks each
//   entry through L1D load replay and ROB writeback, retires in order and
//   drops everything on a flush.
//
//   Handshake rule: a request transfers on a cycle where vld_o & rdy_i are
//   both 1; while vld_o is 1 the payload outputs stay stable until that
//   cycle, and vld_o never depends on the matching rdy_i.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   enq_*                    dispatch enqueue (vld/rdy) and uop payload
//   lsu_l1d_ld_req_*         load request channel to L1D
//   lsu_l1d_st_req_*         store / fence request channel to L1D
//   l1d_lsu_ld_replay_vld_i  replay of the load that handshook last cycle
//   l1d_lsu_wb_*             per-port writeback completions (by ROB index)
//   flush_i                  ROB flush; lsu_l1d_kill_req_o echoes it a cycle later
module lsu_l1d_req_queue #(
    parameter int LSQ_ENTRY_NUM  = 8,
    parameter int WB_PORT_NUM    = 2,
    parameter int ROB_TAG_WIDTH  = 6,
    parameter int PREG_TAG_WIDTH = 6,
    parameter int XLEN           = 64,
    parameter int IDX_W          = 6,
    parameter int OFS_W          = 6,
    parameter int TAG_W          = 8,
    parameter int LDU_OP_WIDTH   = 3,
    parameter int STU_OP_WIDTH   = 2,
    parameter int OP_W           = (LDU_OP_WIDTH > STU_OP_WIDTH) ? LDU_OP_WIDTH : STU_OP_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enq_vld_i,
    output logic                                 enq_rdy_o,
    input  logic [1:0]                           enq_type_i,
    input  logic [ROB_TAG_WIDTH-1:0]             enq_rob_index_i,
    input  logic [PREG_TAG_WIDTH-1:0]            enq_rd_addr_i,
    input  logic [OP_W-1:0]                      enq_opcode_i,
    input  logic [TAG_W+IDX_W+OFS_W-1:0]         enq_addr_i,
    input  logic [XLEN-1:0]                      enq_data_i,
    input  logic                                 l1d_lsu_ld_req_rdy_i,
    output logic                                 lsu_l1d_ld_req_vld_o,
    output logic [ROB_TAG_WIDTH-1:0]             lsu_l1d_ld_req_rob_index_o,
    output logic [PREG_TAG_WIDTH-1:0]            lsu_l1d_ld_req_rd_addr_o,
    output logic [LDU_OP_WIDTH-1:0]              lsu_l1d_ld_req_opcode_o,
    output logic [IDX_W-1:0]                     lsu_l1d_ld_req_index_o,
    output logic [OFS_W-1:0]                     lsu_l1d_ld_req_offset_o,
    output logic [TAG_W-1:0]                     lsu_l1d_ld_req_vtag_o,
    input  logic                                 l1d_lsu_st_req_rdy_i,
    output logic                                 lsu_l1d_st_req_vld_o,
    output logic                                 lsu_l1d_st_req_is_fence_o,
    output logic [ROB_TAG_WIDTH-1:0]             lsu_l1d_st_req_rob_index_o,
    output logic [STU_OP_WIDTH-1:0]              lsu_l1d_st_req_opcode_o,
    output logic [TAG_W+IDX_W+OFS_W-1:0]         lsu_l1d_st_req_paddr_o,
    output logic [XLEN-1:0]                      lsu_l1d_st_req_data_o,
    input  logic                                 l1d_lsu_ld_replay_vld_i,
    input  logic [WB_PORT_NUM-1:0]               l1d_lsu_wb_vld_i,
    input  logic [WB_PORT_NUM*ROB_TAG_WIDTH-1:0] l1d_lsu_wb_rob_index_i,
    input  logic                                 flush_i,
    output logic                                 lsu_l1d_kill_req_o
);
    localparam int AW     = $clog2(LSQ_ENTRY_NUM);
    localparam int PTR_W  = AW + 1;
    localparam int ADDR_W = TAG_W + IDX_W + OFS_W;

    typedef enum logic [1:0] {E_IDLE, E_WAIT, E_ISSUED, E_DONE} ent_state_e;

    typedef struct packed {
        logic [1:0]                typ;
        logic [ROB_TAG_WIDTH-1:0]  rob;
        logic [PREG_TAG_WIDTH-1:0] rd;
        logic [OP_W-1:0]           op;
        logic [ADDR_W-1:0]         addr;
        logic [XLEN-1:0]           data;
    } ent_t;

    ent_state_e       state_q [LSQ_ENTRY_NUM];
    ent_state_e       state_d [LSQ_ENTRY_NUM];
    ent_t             ent_q   [LSQ_ENTRY_NUM];
    ent_t             ent_d   [LSQ_ENTRY_NUM];
    logic [PTR_W-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d;
    logic [PTR_W-1:0] win_ptr_q, win_ptr_d;
    logic             win_q, win_d;
    logic             kill_q, kill_d;

    logic             full, present, iss_is_ld, ld_vld, st_vld, ld_hs, st_hs, is_fence;
    ent_t             iss_ent;

    // Same index with different wrap bits means the tail has lapped the head.
    assign full      = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign enq_rdy_o = ~full & ~flush_i;

    assign iss_ent   = ent_q[issue_q[AW-1:0]];
    // win_q marks the cycle after a load handshake, reserved for its replay.
    assign present   = (state_q[issue_q[AW-1:0]] == E_WAIT) & ~win_q & ~flush_i;
    assign iss_is_ld = (iss_ent.typ == 2'd0);
    assign is_fence  = (iss_ent.typ == 2'd2);
    assign ld_vld    = present & iss_is_ld;
    assign st_vld    = present & ~iss_is_ld;
    assign ld_hs     = ld_vld & l1d_lsu_ld_req_rdy_i;
    assign st_hs     = st_vld & l1d_lsu_st_req_rdy_i;

    // Payload is forced to zero whenever its channel is idle, which also
    // keeps every payload output at 0 while reset is asserted.
    assign lsu_l1d_ld_req_vld_o       = ld_vld;
    assign lsu_l1d_ld_req_rob_index_o = ld_vld ? iss_ent.rob : '0;
    assign lsu_l1d_ld_req_rd_addr_o   = ld_vld ? iss_ent.rd : '0;
    assign lsu_l1d_ld_req_opcode_o    = ld_vld ? iss_ent.op[LDU_OP_WIDTH-1:0] : '0;
    assign lsu_l1d_ld_req_vtag_o      = ld_vld ? iss_ent.addr[ADDR_W-1 -: TAG_W] : '0;
    assign lsu_l1d_ld_req_index_o     = ld_vld ? iss_ent.addr[OFS_W +: IDX_W] : '0;
    assign lsu_l1d_ld_req_offset_o    = ld_vld ? iss_ent.addr[OFS_W-1:0] : '0;

    assign lsu_l1d_st_req_vld_o       = st_vld;
    assign lsu_l1d_st_req_is_fence_o  = st_vld & is_fence;
    assign lsu_l1d_st_req_rob_index_o = st_vld ? iss_ent.rob : '0;
    assign lsu_l1d_st_req_opcode_o    = st_vld ? iss_ent.op[STU_OP_WIDTH-1:0] : '0;
    assign lsu_l1d_st_req_paddr_o     = st_vld ? iss_ent.addr : '0;
    assign lsu_l1d_st_req_data_o      = (st_vld && !is_fence) ? iss_ent.data : '0;

    assign lsu_l1d_kill_req_o         = kill_q;

    always_comb begin
        state_d   = state_q;
        ent_d     = ent_q;
        head_d    = head_q;
        issue_d   = issue_q;
        tail_d    = tail_q;
        win_d     = 1'b0;
        win_ptr_d = win_ptr_q;
        kill_d    = flush_i;

        for (int p = 0; p < WB_PORT_NUM; p++) begin
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                if (l1d_lsu_wb_vld_i[p] && state_q[i] == E_ISSUED &&
                    ent_q[i].rob == l1d_lsu_wb_rob_index_i[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]) begin
                    state_d[i] = E_DONE;
                end
            end
        end

        // Retire looks at the registered state, so a completion retires no
        // earlier than the cycle after its writeback.
        if (state_q[head_q[AW-1:0]] == E_DONE) begin
            state_d[head_q[AW-1:0]] = E_IDLE;
            head_d = head_q + PTR_W'(1);
        end

        if (ld_hs || st_hs) begin
            state_d[issue_q[AW-1:0]] = E_ISSUED;
            issue_d = issue_q + PTR_W'(1);
        end

        if (ld_hs) begin
            win_d     = 1'b1;
            win_ptr_d = issue_q;
        end

        // Nothing issues inside the window, so every entry from win_ptr_q
        // onward is still WAIT and rewinding the issue pointer is safe.
        if (win_q && l1d_lsu_ld_replay_vld_i) begin
            state_d[win_ptr_q[AW-1:0]] = E_WAIT;
            issue_d = win_ptr_q;
        end

        if (enq_vld_i && enq_rdy_o) begin
            state_d[tail_q[AW-1:0]] = E_WAIT;
            ent_d[tail_q[AW-1:0]]   = '{typ: enq_type_i, rob: enq_rob_index_i, rd: enq_rd_addr_i,
                                        op: enq_opcode_i, addr: enq_addr_i, data: enq_data_i};
            tail_d = tail_q + PTR_W'(1);
        end

        if (flush_i) begin
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                state_d[i] = E_IDLE;
            end
            head_d    = '0;
            issue_d   = '0;
            tail_d    = '0;
            win_d     = 1'b0;
            win_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                state_q[i] <= E_IDLE;
                ent_q[i]   <= '0;
            end
            head_q    <= '0;
            issue_q   <= '0;
            tail_q    <= '0;
            win_q     <= 1'b0;
            win_ptr_q <= '0;
            kill_q    <= 1'b0;
        end else begin
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                state_q[i] <= state_d[i];
                ent_q[i]   <= ent_d[i];
            end
            head_q    <= head_d;
            issue_q   <= issue_d;
            tail_q    <= tail_d;
            win_q     <= win_d;
            win_ptr_q <= win_ptr_d;
            kill_q    <= kill_d;
        end
    end
endmodule

// File: doc/lsu_l1d_req_queue.md
Name: lsu_l1d_req_queue

Overview:
Synthesisable, parametrised LSU request queue sitting between dispatch and the L1D load/store request ports. It holds up to LSQ_ENTRY_NUM memory uops and issues them in program order, loads on the L1D load channel and stores/fences on the store channel. It tracks each entry through L1D replay and ROB writeback, retires entries in order, and flushes all entries on a kill.

Parameters:
LSQ_ENTRY_NUM, 8, queue depth; power of two, at least 2; pointer width is $clog2(LSQ_ENTRY_NUM) plus 1 wrap bit.
WB_PORT_NUM, 2, number of L1D writeback ports (LSU_ADDR_PIPE_COUNT + LSU_DATA_PIPE_COUNT).
ROB_TAG_WIDTH / PREG_TAG_WIDTH / XLEN, package values, widths of ROB index, physical register tag and data.
IDX_W / OFS_W / TAG_W, L1D_INDEX_WIDTH / L1D_OFFSET_WIDTH / L1D_TAG_WIDTH, L1D address split.
OP_W, max(LDU_OP_WIDTH, STU_OP_WIDTH), enqueue opcode width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
enq_vld_i  in  1  enqueue request
enq_rdy_o  out  1  queue can accept an enqueue
enq_type_i  in  2  0 = load, 1 = store, 2 = fence; 3 is illegal
enq_rob_index_i  in  ROB_TAG_WIDTH  ROB index of the uop
enq_rd_addr_i  in  PREG_TAG_WIDTH  destination preg (loads)
enq_opcode_i  in  OP_W  LDU or STU opcode; LSBs used on each channel
enq_addr_i  in  TAG_W+IDX_W+OFS_W  {tag,index,offset}; vtag for loads, ptag for stores
enq_data_i  in  XLEN  store data
l1d_lsu_ld_req_rdy_i  in  1  L1D load channel ready
lsu_l1d_ld_req_vld_o  out  1  load request valid
lsu_l1d_ld_req_rob_index_o  out  ROB_TAG_WIDTH  load ROB index
lsu_l1d_ld_req_rd_addr_o  out  PREG_TAG_WIDTH  load destination preg
lsu_l1d_ld_req_opcode_o  out  LDU_OP_WIDTH  load opcode
lsu_l1d_ld_req_index_o  out  IDX_W  load index
lsu_l1d_ld_req_offset_o  out  OFS_W  load offset
lsu_l1d_ld_req_vtag_o  out  TAG_W  load virtual tag
l1d_lsu_st_req_rdy_i  in  1  L1D store channel ready
lsu_l1d_st_req_vld_o  out  1  store/fence request valid
lsu_l1d_st_req_is_fence_o  out  1  request is a fence
lsu_l1d_st_req_rob_index_o  out  ROB_TAG_WIDTH  store ROB index
lsu_l1d_st_req_opcode_o  out  STU_OP_WIDTH  store opcode
lsu_l1d_st_req_paddr_o  out  TAG_W+IDX_W+OFS_W  store physical address
lsu_l1d_st_req_data_o  out  XLEN  store data; 0 for fences
l1d_lsu_ld_replay_vld_i  in  1  replay of the load that handshook in the previous cycle
l1d_lsu_wb_vld_i  in  WB_PORT_NUM  writeback valid, one bit per port
l1d_lsu_wb_rob_index_i  in  WB_PORT_NUM*ROB_TAG_WIDTH  writeback ROB index per port
flush_i  in  1  pipeline flush from ROB
lsu_l1d_kill_req_o  out  1  kill pulse to L1D

Behaviour:
- Storage: circular buffer with head, issue and tail pointers, each with a wrap bit. Entry state is IDLE, WAIT, ISSUED or DONE.
- Enqueue: enq_rdy_o = ~full & ~flush_i, where full is computed from registered pointers. On enq_vld_i & enq_rdy_o the tail entry goes to WAIT and tail increments.
- Issue: only the entry at the issue pointer is presented, and only when it is in WAIT. A load drives the ld channel; a store or fence drives the st channel. At most one channel is valid per cycle. Payload comes combinationally from the entry registers and is held stable until the handshake.
- Handshake (vld & rdy): entry goes WAIT to ISSUED and the issue pointer increments.
- Replay window: the cycle after a load handshake, both vld_o outputs are 0.
- Replay: if l1d_lsu_ld_replay_vld_i is 1 in that window cycle, the load returns to WAIT and the issue pointer rewinds to it. The load is re-presented the following cycle. Replay outside the window is ignored.
- Writeback: for each port with its wb_vld bit set, an ISSUED entry whose ROB index matches goes to DONE. Several ports in one cycle may each complete a different entry. Unmatched writebacks are ignored.
- Retire: if the head entry is DONE, it goes to IDLE and head increments. At most 1 retire per cycle. Enqueue and retire in the same cycle are both honoured.
- Flush: while flush_i = 1, both vld_o and enq_rdy_o are 0. On the clock edge, all entries go to IDLE and all pointers go to 0. lsu_l1d_kill_req_o is registered, =1 for exactly the cycle after each flush_i cycle.
- Reset (asynchronous): all entries IDLE, pointers 0, kill_req_o 0, both vld_o 0, all payload outputs 0. enq_rdy_o = 1 once reset is released.

Test Plan:
- Enqueue loads with ROB indices 0..7, ld rdy=1, writeback each ROB index 2 cycles after its handshake -> handshakes land on alternate cycles, retirement is in order 0..7, queue ends empty.
- Hold st rdy=0 and enqueue 9 stores -> enq_rdy_o=0 after the 8th, the 9th stalls. Raise rdy -> stores issue on consecutive cycles, and paddr of the store enqueued with enq_addr_i=0x12345 reads 0x12345.
- Load with ROB index 5 handshakes, replay_vld=1 the next cycle -> the same load (ROB 5, same vtag/index/offset) is re-presented 2 cycles after the first handshake; no younger entry issues in between.
- ROB 3 and 4 are both ISSUED; writeback port 1 completes ROB 4, then port 0 completes ROB 3 one cycle later -> head does not retire early; ROB 3 and ROB 4 retire on consecutive cycles.
- Queue holds 5 entries, 2 of them ISSUED; pulse flush_i for 1 cycle -> kill_req_o=1 for exactly 1 cycle, queue empty, a late writeback for an old ROB index changes nothing.
- Fence enqueued behind 2 stores -> presented on the st channel with is_fence_o=1 and data 0. Assert rst low mid-handshake -> all vld_o drop to 0 immediately, without waiting for a clock edge.
